// File: rtl/seg7_num_display_if.sv
// ============================================================================
// Module  : seg7_num_display_if
// Brief   : Request/display bundle between a value source and the 7-seg driver.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface seg7_num_display_if #(
  parameter int N_DIGITS = 4,
  parameter int W        = 14
);
  logic                    i_valid;
  logic [W-1:0]            i_num;
  logic [N_DIGITS-1:0]     i_DP;
  logic                    o_ready;
  logic                    o_busy;
  logic [8*N_DIGITS-1:0]   o_SEG;
  logic                    o_overflow;

  modport master (
    output i_valid, i_num, i_DP,
    input  o_ready, o_busy, o_SEG, o_overflow
  );

  modport slave (
    input  i_valid, i_num, i_DP,
    output o_ready, o_busy, o_SEG, o_overflow
  );
endinterface

`default_nettype wire

// File: rtl/seg7_num_display.sv
// ============================================================================
// Module  : seg7_num_display
// Brief   : Sequential binary-to-BCD converter driving N active-low 7-seg digits.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg7_num_display #(
  parameter int N_DIGITS = 4,
  parameter int W        = 14,
  parameter int BLANK_LZ = 1
) (
  input  logic               i_CLK,
  input  logic               i_RSTn,
  seg7_num_display_if.slave  bus
);

  localparam int c_BCD_W = 4 * N_DIGITS;
  localparam int c_SEG_W = 8 * N_DIGITS;
  localparam int c_CNT_W = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_ready;

  logic [W-1:0]         r_shreg;
  logic [c_BCD_W-1:0]   r_bcd;
  logic [N_DIGITS-1:0]  r_dp;
  logic                 r_ovf;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_SEG_W-1:0]   r_seg;
  logic                 r_overflow;

  logic [c_BCD_W-1:0]   w_bcd_adj;
  logic                 w_last;
  logic [N_DIGITS-1:0]  w_nz;
  logic [N_DIGITS-1:0]  w_blank;
  logic [c_SEG_W-1:0]   w_seg;

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign w_last = (r_cnt == c_CNT_W'(W - 1));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.i_valid) w_state_nxt = S_CONV;
      end
      S_CONV: begin
        if (w_last) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- double-dabble
  generate
    for (genvar k = 0; k < N_DIGITS; k++) begin : g_adj
      logic [3:0] w_nib;
      assign w_nib              = r_bcd[4*k +: 4];
      assign w_bcd_adj[4*k +: 4] = (w_nib >= 4'd5) ? (w_nib + 4'd3) : w_nib;
    end
  endgenerate

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_shreg    <= '0;
      r_bcd      <= '0;
      r_dp       <= '0;
      r_ovf      <= 1'b0;
      r_cnt      <= '0;
      r_seg      <= '1;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_valid) begin
            r_shreg <= bus.i_num;
            r_dp    <= bus.i_DP;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
          end
        end
        S_CONV: begin
          // The bit leaving the top nibble belongs to a digit we cannot show.
          r_bcd   <= {w_bcd_adj[c_BCD_W-2:0], r_shreg[W-1]};
          r_shreg <= {r_shreg[W-2:0], 1'b0};
          if (w_bcd_adj[c_BCD_W-1]) r_ovf <= 1'b1;
          r_cnt   <= r_cnt + 1'b1;
        end
        S_LOAD: begin
          r_seg      <= w_seg;
          r_overflow <= r_ovf;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- segment encode
  generate
    for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
      assign w_nz[k] = (|r_bcd[4*k +: 4]) | r_dp[k];
      assign w_seg[8*k +: 8] = r_ovf      ? 8'hBF :
                               w_blank[k] ? 8'hFF :
                               {~r_dp[k], f_seg(r_bcd[4*k +: 4])};
    end
  endgenerate

  // A digit stays visible once any more-significant digit (or itself) is non-zero or dotted.
  always_comb begin
    logic run;
    run     = 1'b0;
    w_blank = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      run        = run | w_nz[k];
      w_blank[k] = (BLANK_LZ != 0) && (k != 0) && !run;
    end
  end

  assign bus.o_ready    = w_ready;
  assign bus.o_busy     = ~w_ready;
  assign bus.o_SEG      = r_seg;
  assign bus.o_overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_seg7_num_display.sv
// ============================================================================
// Module  : tb_seg7_num_display
// Brief   : Directed self-checking bench for seg7_num_display (both blanking modes).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seg7_num_display;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  seg7_num_display_if #(.N_DIGITS(4), .W(14)) if0 ();
  seg7_num_display_if #(.N_DIGITS(4), .W(14)) if1 ();

  seg7_num_display #(.N_DIGITS(4), .W(14), .BLANK_LZ(1)) dut0 (
    .i_CLK  (clk),
    .i_RSTn (rst_n),
    .bus    (if0)
  );

  seg7_num_display #(.N_DIGITS(4), .W(14), .BLANK_LZ(0)) dut1 (
    .i_CLK  (clk),
    .i_RSTn (rst_n),
    .bus    (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? if1.o_ready : if0.o_ready;
  endfunction

  function automatic logic [31:0] seg(input bit sel);
    return sel ? if1.o_SEG : if0.o_SEG;
  endfunction

  function automatic logic ovf(input bit sel);
    return sel ? if1.o_overflow : if0.o_overflow;
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [13:0] n, input logic [3:0] dp);
    if (sel) begin
      if1.i_valid = v; if1.i_num = n; if1.i_DP = dp;
    end else begin
      if0.i_valid = v; if0.i_num = n; if0.i_DP = dp;
    end
  endtask

  // Called just after a falling edge with the DUT idle; accept happens on the next rising edge.
  task automatic run(input bit sel, input logic [13:0] n, input logic [3:0] dp, input bit inject,
                     input logic [31:0] exp_seg, input logic exp_ovf, input string tag);
    logic [31:0] prev;
    int          lat;
    prev = seg(sel);
    drive(sel, 1'b1, n, dp);
    @(negedge clk);
    drive(sel, 1'b0, n, dp);
    lat = 0;
    while (!rdy(sel) && lat < 40) begin
      lat++;
      if (inject && lat == 3) drive(sel, 1'b1, 14'd99, 4'b0000);
      if (inject && lat == 4) drive(sel, 1'b0, 14'd99, 4'b0000);
      if (lat == 8) chk({tag, "_hold"}, 64'(seg(sel)), 64'(prev));
      @(negedge clk);
    end
    chk({tag, "_lat"}, 64'(lat), 64'd15);
    chk({tag, "_seg"}, 64'(seg(sel)), 64'(exp_seg));
    chk({tag, "_ovf"}, 64'(ovf(sel)), 64'(exp_ovf));
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    drive(1'b0, 1'b0, 14'd0, 4'd0);
    drive(1'b1, 1'b0, 14'd0, 4'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_seg",   64'(if0.o_SEG),      64'hFFFFFFFF);
    chk("rst_ovf",   64'(if0.o_overflow), 64'd0);
    chk("rst_ready", 64'(if0.o_ready),    64'd1);
    chk("rst_busy",  64'(if0.o_busy),     64'd0);

    run(1'b0, 14'd1234,  4'b0000, 1'b0, 32'hF9A4B099, 1'b0, "v1234");
    run(1'b0, 14'd7,     4'b0000, 1'b0, 32'hFFFFFFF8, 1'b0, "v7");
    run(1'b0, 14'd0,     4'b0000, 1'b0, 32'hFFFFFFC0, 1'b0, "v0");
    run(1'b1, 14'd7,     4'b0000, 1'b0, 32'hC0C0C0F8, 1'b0, "v7_noblank");
    run(1'b0, 14'd5,     4'b0010, 1'b0, 32'hFFFF4092, 1'b0, "v5_dp");
    run(1'b0, 14'd10000, 4'b0000, 1'b0, 32'hBFBFBFBF, 1'b1, "v10000");
    run(1'b0, 14'd16383, 4'b1111, 1'b0, 32'hBFBFBFBF, 1'b1, "v16383");
    run(1'b0, 14'd9999,  4'b0000, 1'b0, 32'h90909090, 1'b0, "v9999");
    run(1'b0, 14'd42,    4'b0000, 1'b1, 32'hFFFF99A4, 1'b0, "v42_ignore99");

    // Asynchronous reset between edges while idle.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_seg",   64'(if0.o_SEG),      64'hFFFFFFFF);
    chk("arst_ready", 64'(if0.o_ready),    64'd1);
    chk("arst1_seg",  64'(if1.o_SEG),      64'hFFFFFFFF);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Overflowing request aborted mid-conversion.
    run(1'b0, 14'd9999, 4'b0000, 1'b0, 32'h90909090, 1'b0, "pre_abort");
    drive(1'b0, 1'b1, 14'd16383, 4'b0000);
    @(negedge clk);
    drive(1'b0, 1'b0, 14'd16383, 4'b0000);
    repeat (12) @(negedge clk);
    chk("conv_busy", 64'(if0.o_busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_seg",   64'(if0.o_SEG),      64'hFFFFFFFF);
    chk("abort_ovf",   64'(if0.o_overflow), 64'd0);
    chk("abort_ready", 64'(if0.o_ready),    64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(1'b0, 14'd3, 4'b0000, 1'b0, 32'hFFFFFFB0, 1'b0, "v3_after_abort");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg7_num_display.md
# seg7_num_display

Parametrised multi-digit 7-segment driver. Accepts an unsigned binary value through a valid/ready handshake and converts it to BCD sequentially (shift-and-add-3, one bit per clock). It then registers the active-low segment pattern for N_DIGITS displays, with leading-zero blanking, per-digit decimal points and overflow indication. It sits between control/monitoring logic and the board HEX display pins, replacing per-display combinational lookup chains.

## Interface
- N_DIGITS, 4: number of displays, legal range 1..8.
- W, 14: width of i_num, legal range 4..32.
- BLANK_LZ, 1: 1 = blank leading zeros; 0 = show every digit.

Ports:
- i_CLK  in  1  system clock; the only clock.
- i_RSTn  in  1  reset, asynchronous, active-low.
- i_valid  in  1  request; i_num and i_DP are sampled on a cycle where i_valid & o_ready.
- i_num  in  W  unsigned value to display.
- i_DP  in  N_DIGITS  decimal-point request per digit; 1 = point lit.
- o_ready  out  1  high only in IDLE.
- o_busy  out  1  equals ~o_ready.
- o_SEG  out  8*N_DIGITS  digit k occupies [8k+7:8k] as {dp,g,f,e,d,c,b,a}; digit 0 is least significant; 0 = segment ON.
- o_overflow  out  1  registered; set when the last conversion did not fit in N_DIGITS.

## Operation
- State machine:
  - IDLE: on i_valid, capture i_num into a shift register, i_DP into dp_r, clear the BCD register and overflow flag, clear bit counter → CONV.
  - CONV: each cycle, add 3 to every BCD nibble ≥5, then shift {bcd, shreg} left by one. If the bit shifted out of the top nibble is 1, set the sticky ovf. Increment the counter; after the W-th shift → LOAD.
  - LOAD: register o_SEG and o_overflow from bcd/dp_r/ovf → IDLE.
- Segment codes, 7-bit {g..a}: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, dash=0111111, blank=1111111.
- The dp bit equals ~dp_r[k].
- Blanking (BLANK_LZ=1): digit k>0 is blanked (8'hFF) iff, for all j≥k, bcd digit j==0 and dp_r[j]==0. Digit 0 is never blanked.
- Overflow (ovf=1): every digit shows a dash with dp off (8'hBF), o_overflow=1, and i_DP is ignored.
- i_valid while busy is ignored; there is no queue and no request is lost silently (o_ready is low).
- Outputs hold their last value between conversions.

## Timing
- Reset (asynchronous, any state): state=IDLE, o_SEG all 1 (all displays dark), o_overflow=0, o_ready=1, o_busy=0. Internal registers are cleared.
- Release is synchronous to the first i_CLK edge with i_RSTn high.
- Accept at edge A: o_ready low after A.
  - Edges A+1..A+W perform the W shifts.
  - Edge A+W+1 updates o_SEG/o_overflow and raises o_ready.
- Latency: accept → new o_SEG is W+1 cycles. Throughput is one value per W+2 cycles; a back-to-back accept is possible on the first cycle o_ready is high.
- o_SEG never shows intermediate BCD values; it changes only on the LOAD edge.
- Reset asserted mid-CONV aborts the conversion; the next accept starts clean with no residual ovf.
- Width rule: the BCD register is 4*N_DIGITS bits; no value of i_num is illegal. Values ≥10^N_DIGITS produce the overflow display.

## Test plan
All scenarios use defaults: N_DIGITS=4, W=14, BLANK_LZ=1.
- Reset, then idle: o_SEG=32'hFFFFFFFF, o_overflow=0, o_ready=1. Assert i_RSTn low asynchronously between edges → outputs return to these values immediately.
- i_num=1234, i_DP=0 → after exactly 15 cycles o_SEG=32'hF9A4B099, o_overflow=0. o_ready is low for 15 cycles, then high.
- i_num=7, then i_num=0 → o_SEG=32'hFFFFFFF8, then 32'hFFFFFFC0. Repeat 7 with BLANK_LZ=0 → 32'hC0C0C0F8.
- i_num=5, i_DP=4'b0010 → o_SEG=32'hFFFF4092 (displays "0.5").
- i_num=10000 (and 16383) → o_SEG=32'hBFBFBFBF, o_overflow=1. A following i_num=9999 → 32'h90909090, o_overflow=0.
- Issue i_num=42, then pulse i_valid with i_num=99 during CONV → display is 42 (32'hFFFF99A4). Pulse reset mid-CONV on a new request → o_SEG returns to all 1. The next request for 3 yields 32'hFFFFFFB0.
